// File: rtl/side_car_detector.sv
// side_car_detector
// Conditions the raw side-road loop signal into the controller's car-waiting
// request C: synchronise, debounce, count queued vehicles, release them on
// departures during side green, and force a request if the loop sticks.
module side_car_detector #(
    parameter int DEBOUNCE    = 4,
    parameter int STUCK_LIMIT = 1000,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loop_raw,
    input  logic             SG,
    output logic             C,
    output logic [CNT_W-1:0] car_count,
    output logic             car_pulse,
    output logic             loop_fault
);

    localparam int DB_W = $clog2(DEBOUNCE) + 1;
    localparam int ST_W = $clog2(STUCK_LIMIT) + 1;

    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [ST_W-1:0]  ST_LAST = ST_W'(STUCK_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_OCCUPIED = 2'd1;
    localparam logic [1:0] ST_FAULT    = 2'd2;

    logic            s1;
    logic            s2;
    logic            loop_db;
    logic            loop_db_q;
    logic [DB_W-1:0] db_cnt;
    logic            rise;
    logic            fall;

    logic [CNT_W-1:0] car_count_next;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [ST_W-1:0]  stuck_cnt;
    logic [ST_W-1:0]  stuck_next;

    // Two-flop synchroniser for the asynchronous loop input
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= loop_raw;
            s2 <= s1;
        end
    end

    // Debouncer: accept a change only after it persists DEBOUNCE cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            loop_db <= 1'b0;
            db_cnt  <= '0;
        end else if (s2 == loop_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            loop_db <= s2;
            db_cnt  <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Previous debounced value for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            loop_db_q <= 1'b0;
        end else begin
            loop_db_q <= loop_db;
        end
    end

    // Edge detect and saturating queue update
    always_comb begin
        rise           = loop_db & ~loop_db_q;
        fall           = ~loop_db & loop_db_q;
        car_count_next = car_count;
        if (rise) begin
            if (car_count != CNT_MAX) begin
                car_count_next = car_count + 1'b1;
            end
        end else if (fall && SG) begin
            if (car_count != '0) begin
                car_count_next = car_count - 1'b1;
            end
        end
    end

    // Stuck-loop watchdog next-state logic
    always_comb begin
        state_next = state;
        stuck_next = stuck_cnt;
        case (state)
            ST_EMPTY: begin
                stuck_next = '0;
                if (loop_db) begin
                    state_next = ST_OCCUPIED;
                end
            end
            ST_OCCUPIED: begin
                if (!loop_db) begin
                    state_next = ST_EMPTY;
                    stuck_next = '0;
                end else begin
                    stuck_next = stuck_cnt + 1'b1;
                    if (stuck_cnt == ST_LAST) begin
                        state_next = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                if (!loop_db) begin
                    state_next = ST_EMPTY;
                    stuck_next = '0;
                end
            end
            default: begin
                state_next = ST_EMPTY;
                stuck_next = '0;
            end
        endcase
    end

    // Output and watchdog registers; C is built from next-state values so it
    // updates on the same edge as the queue and the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            car_count <= '0;
            car_pulse <= 1'b0;
            state     <= ST_EMPTY;
            stuck_cnt <= '0;
            C         <= 1'b0;
        end else begin
            car_count <= car_count_next;
            car_pulse <= rise;
            state     <= state_next;
            stuck_cnt <= stuck_next;
            C         <= (car_count_next != '0) | (state_next == ST_FAULT);
        end
    end

    assign loop_fault = (state == ST_FAULT);

endmodule
